// File: rtl/uart_baud_gen.sv
// Fractional-divisor baud tick generator: emits bit-start and mid-bit pulses for
// a fixed-length frame, with abort and rejected-start (bad divisor) reporting.
module uart_baud_gen #(
    parameter int DIV_WD     = 16,
    parameter int FRAC_WD    = 4,
    parameter int FRAME_BITS = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIV_WD-1:0] div_int,
    input  logic [FRAC_WD-1:0] div_frac,
    input  logic              tx_start,
    input  logic              tx_abort,
    output logic              bps_clk,
    output logic              mid_tick,
    output logic              busy,
    output logic              frame_done,
    output logic              cfg_err
);

    localparam int IDX_WD = $clog2(FRAME_BITS + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               r_state;
    state_t               w_nextState;
    logic [DIV_WD-1:0]    r_divInt;
    logic [FRAC_WD-1:0]   r_divFrac;
    logic [DIV_WD-1:0]    r_count;
    logic [FRAC_WD-1:0]   r_acc;
    logic [IDX_WD-1:0]    r_bitIdx;
    logic                 r_bps;
    logic                 r_mid;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_cfgErr;

    logic [FRAC_WD:0]     w_fracSum;
    logic                 w_carry;
    logic [DIV_WD:0]      w_countNext;
    logic [DIV_WD:0]      w_periodLen;
    logic [DIV_WD-1:0]    w_half;
    logic                 w_periodEnd;
    logic                 w_lastEnd;
    logic                 w_accept;
    logic                 w_reject;

    // The carry of the fractional accumulator stretches the current period by one cycle
    assign w_fracSum   = {1'b0, r_acc} + {1'b0, r_divFrac};
    assign w_carry     = w_fracSum[FRAC_WD];
    assign w_countNext = {1'b0, r_count} + {{DIV_WD{1'b0}}, 1'b1};
    assign w_periodLen = {1'b0, r_divInt} + {{DIV_WD{1'b0}}, w_carry};
    assign w_half      = r_divInt >> 1;
    assign w_periodEnd = (r_state == RUN) && (w_countNext == w_periodLen);
    assign w_lastEnd   = w_periodEnd && (r_bitIdx == IDX_WD'(FRAME_BITS));
    assign w_accept    = (r_state == IDLE) && tx_start && (div_int >= DIV_WD'(2));
    assign w_reject    = (r_state == IDLE) && tx_start && (div_int <  DIV_WD'(2));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (w_accept) w_nextState = RUN;
            RUN:  if (tx_abort || w_lastEnd) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_divInt  <= '0;
            r_divFrac <= '0;
            r_count   <= '0;
            r_acc     <= '0;
            r_bitIdx  <= '0;
            r_bps     <= 1'b0;
            r_mid     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cfgErr  <= 1'b0;
        end else begin
            r_bps    <= 1'b0;
            r_mid    <= 1'b0;
            r_done   <= 1'b0;
            r_cfgErr <= w_reject;
            r_busy   <= (w_nextState == RUN);
            if (w_accept) begin
                r_divInt  <= div_int;
                r_divFrac <= div_frac;
                r_count   <= '0;
                r_acc     <= '0;
                r_bitIdx  <= '0;
            end
            // An abort freezes the counters; the next accepted start reinitialises them
            if (r_state == RUN && !tx_abort) begin
                r_bps  <= (r_count == '0);
                r_mid  <= (r_count == w_half);
                r_done <= w_lastEnd;
                if (r_count == '0) begin
                    r_bitIdx <= r_bitIdx + IDX_WD'(1);
                end
                if (w_periodEnd) begin
                    r_count <= '0;
                    r_acc   <= w_fracSum[FRAC_WD-1:0];
                end else begin
                    r_count <= w_countNext[DIV_WD-1:0];
                end
            end
        end
    end

    assign bps_clk    = r_bps;
    assign mid_tick   = r_mid;
    assign busy       = r_busy;
    assign frame_done = r_done;
    assign cfg_err    = r_cfgErr;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen: every output is compared each cycle
// against a frame-timeline model built from the per-period length arithmetic.
module tb_uart_baud_gen;

    localparam int DW = 16;
    localparam int FW = 4;
    localparam int FB = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] div_int;
    logic [FW-1:0] div_frac;
    logic          tx_start;
    logic          tx_abort;
    logic          bps_clk;
    logic          mid_tick;
    logic          busy;
    logic          frame_done;
    logic          cfg_err;

    int checks = 0;
    int errors = 0;

    uart_baud_gen #(.DIV_WD(DW), .FRAC_WD(FW), .FRAME_BITS(FB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .div_int    (div_int),
        .div_frac   (div_frac),
        .tx_start   (tx_start),
        .tx_abort   (tx_abort),
        .bps_clk    (bps_clk),
        .mid_tick   (mid_tick),
        .busy       (busy),
        .frame_done (frame_done),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    // Length of bit period k: the k-th fractional share rounds up whenever the
    // running total of fractional cycles crosses a whole cycle.
    function automatic int periodLen(input int k, input int d, input int f);
        return d + (((k + 1) * f) >> FW) - ((k * f) >> FW);
    endfunction

    function automatic int frameLen(input int d, input int f);
        return FB * d + ((FB * f) >> FW);
    endfunction

    function automatic int bpsAt(input int k, input int d, input int f);
        int t = 1;
        for (int j = 0; j < k; j++) t += periodLen(j, d, f);
        return t;
    endfunction

    // Expected {busy, bps_clk, mid_tick, frame_done, cfg_err} in cycle n after the accepting edge
    function automatic logic [4:0] modelAt(input int n, input int d, input int f, input int abortN);
        logic [4:0] e = 5'b0;
        if (abortN >= 0 && n > abortN) return 5'b0;
        e[4] = (n < frameLen(d, f));
        e[1] = (n == frameLen(d, f));
        for (int k = 0; k < FB; k++) begin
            if (n == bpsAt(k, d, f)) e[3] = 1'b1;
            if (n == bpsAt(k, d, f) + d / 2) e[2] = 1'b1;
        end
        return e;
    endfunction

    task automatic checkOutput(input string tag, input int n, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {busy, bps_clk, mid_tick, frame_done, cfg_err};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s n=%0d observed %b expected %b (busy,bps,mid,done,cfg)", tag, n, obs, exp);
        end
    endtask

    // Starts a frame at the current falling edge and checks every cycle until idle;
    // the divisor inputs are scrambled after acceptance to prove they are latched.
    task automatic applyStimulus(input string tag, input int d, input int f,
                                 input int abortN, input bit collide);
        int lastN;
        lastN = (abortN >= 0) ? abortN + 2 : frameLen(d, f) + 1;
        div_int  = DW'(d);
        div_frac = FW'(f);
        tx_start = 1'b1;
        for (int n = 0; n <= lastN; n++) begin
            @(negedge clk);
            checkOutput(tag, n, modelAt(n, d, f, abortN));
            tx_abort = (n == abortN);
            tx_start = collide && (n == abortN);
            div_int  = DW'($urandom_range(0, 20));
            div_frac = FW'($urandom);
        end
        tx_abort = 1'b0;
        tx_start = 1'b0;
    endtask

    initial begin
        int d;
        int f;
        int tot;
        rst_n    = 1'b0;
        tx_start = 1'b0;
        tx_abort = 1'b0;
        div_int  = '0;
        div_frac = '0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset", 0, 5'b0);
        rst_n = 1'b1;
        tx_abort = 1'b1;
        @(negedge clk);
        checkOutput("idle_abort", 0, 5'b0);
        tx_abort = 1'b0;

        applyStimulus("int_div", 5, 0, -1, 1'b0);
        applyStimulus("frac_div_a", 5, 8, -1, 1'b0);
        applyStimulus("frac_div_b", 5, 8, -1, 1'b0);
        applyStimulus("min_div", 2, 0, -1, 1'b0);
        applyStimulus("min_div_frac", 2, 15, -1, 1'b0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus("random", $urandom_range(2, 12), $urandom_range(0, 15), -1, 1'b0);
        end

        applyStimulus("abort", 5, 0, bpsAt(3, 5, 0) + 3, 1'b0);
        applyStimulus("after_abort", 5, 0, -1, 1'b0);
        d = $urandom_range(2, 12);
        f = $urandom_range(0, 15);
        applyStimulus("rand_abort", d, f, $urandom_range(0, frameLen(d, f) - 1), 1'b0);
        applyStimulus("collide", 6, 3, bpsAt(2, 6, 3), 1'b1);

        // Rejected start: divisor below two held for three cycles
        div_int  = DW'($urandom_range(0, 1));
        tx_start = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            checkOutput("cfg_err", n, (n < 3) ? 5'b00001 : 5'b0);
            if (n == 2) tx_start = 1'b0;
        end

        // Held start: back-to-back frames with a single idle cycle between them
        d = 4;
        f = 5;
        tot = frameLen(d, f);
        div_int  = DW'(d);
        div_frac = FW'(f);
        tx_start = 1'b1;
        for (int n = 0; n <= 2 * tot + 2; n++) begin
            @(negedge clk);
            checkOutput("back2back", n,
                        (n <= tot) ? modelAt(n, d, f, -1) : modelAt(n - tot - 1, d, f, -1));
            if (n == 2 * tot + 1) tx_start = 1'b0;
        end

        // Synchronous reset in the middle of a frame
        d = 7;
        f = 3;
        div_int  = DW'(d);
        div_frac = FW'(f);
        tx_start = 1'b1;
        for (int n = 0; n <= 24; n++) begin
            @(negedge clk);
            checkOutput("mid_reset", n, (n <= 20) ? modelAt(n, d, f, -1) : 5'b0);
            tx_start = 1'b0;
            rst_n    = !(n == 20 || n == 21);
        end
        applyStimulus("post_reset", 3, 11, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_baud_gen.md
# uart_baud_gen

Parametrised, runtime-programmable baud tick generator for the UART TX/RX datapaths. It supersedes the fixed-divisor TX bit clock with the following additions:
- a fractional divisor (integer + fractional cycles per bit, loaded at frame start);
- a mid-bit tick for RX sampling;
- an internal frame-length counter that ends the frame on its own;
- an abort input and a configuration-error flag.

It sits between the register block (divisor fields) and the TX shifter / RX sampler.

## Interface
Parameters:
- DIV_WD, 16: width of the integer divisor field; max bit period 2^DIV_WD cycles.
- FRAC_WD, 4: width of the fractional divisor field; resolution 1/2^FRAC_WD cycle.
- FRAME_BITS, 10: bit periods per frame (start + data + parity + stop).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. One clock; reset is synchronous and active-low.
- div_int  in  DIV_WD  integer cycles per bit; sampled only when a start is accepted.
- div_frac  in  FRAC_WD  fractional cycles per bit, in units of 2^-FRAC_WD; sampled with div_int.
- tx_start  in  1  frame request; level, acted on in IDLE only.
- tx_abort  in  1  terminate the current frame immediately.
- bps_clk  out  1  one-cycle pulse at the start of each bit period.
- mid_tick  out  1  one-cycle pulse at mid-bit.
- busy  out  1  high while in RUN.
- frame_done  out  1  one-cycle pulse after the last bit period completes normally.
- cfg_err  out  1  one-cycle pulse when a start is rejected.

## Operation
- FSM states: IDLE, RUN.
  - IDLE → RUN when tx_start=1 and div_int≥2.
  - RUN → IDLE on tx_abort=1, or at the end of the last period.
- Start acceptance (accepting edge):
  - div_int and div_frac are latched into shadow registers. Later input changes are ignored until the next start.
  - count←0, bit_idx←0, acc←0.
- Rejected start: tx_start with div_int<2 in IDLE. The FSM stays in IDLE and cfg_err pulses one cycle. It pulses every cycle the request persists.
- Bit period k has length P_k = div_int + c_k.
  - c_k is the carry out of (acc + div_frac), an FRAC_WD+1 bit sum.
  - acc takes the low FRAC_WD bits at each period end.
  - The average period is div_int + div_frac/2^FRAC_WD. acc starts at 0 in every frame.
- count (DIV_WD bits) runs 0..P_k−1 and wraps to 0 at period end. P_k ≤ 2^DIV_WD, so no overflow.
- bit_idx increments on each bps_clk pulse.
- Normal completion: at the period end where bit_idx=FRAME_BITS, the FSM returns to IDLE and frame_done pulses.
- Abort:
  - tx_abort in RUN goes to IDLE at that edge.
  - No frame_done is issued.
  - A pending bps_clk or mid_tick is suppressed.
  - tx_abort in IDLE has no effect.
- tx_start in RUN is ignored. tx_start and tx_abort together in RUN means abort wins, with no restart in the same cycle.
- After returning to IDLE, a still-high tx_start starts a new frame on the following edge.

## Timing
- Reset values: all outputs 0, state IDLE, count 0, acc 0, bit_idx 0. Reset mid-frame clears everything at the next edge, with no frame_done.
- All outputs are registered. Take E0 as the accepting edge.
  - busy rises at E0.
  - The first bps_clk is high in the cycle after E1. It is generated from count==0 in RUN.
  - Later bps_clk pulses follow at intervals P_0, P_1, …
- mid_tick is high floor(div_int/2) cycles after each bps_clk. It is generated from count==floor(div_int/2) in RUN.
- busy stays high for exactly ΣP_k cycles, k=0..FRAME_BITS−1.
- frame_done is high in the first cycle busy is low. It is set on the same edge that clears busy.
- With div_int=2, mid_tick falls one cycle after bps_clk. bps_clk and mid_tick are never high in the same cycle.

## Test plan
- Integer divisor: div_int=5, div_frac=0, FRAME_BITS=10, tx_start pulse.
  - busy is high 50 cycles.
  - 10 bps_clk pulses, 5 cycles apart; the first is in the 2nd busy cycle.
  - mid_tick follows each bps_clk by 2 cycles.
  - One frame_done immediately after busy falls.
- Fractional divisor: div_int=5, div_frac=8, FRAC_WD=4.
  - bps_clk spacings are 5,6,5,6,…
  - busy is high 55 cycles.
  - A second frame repeats the identical spacing, since acc restarts at 0.
- Abort: tx_abort asserted 3 cycles after the 4th bps_clk.
  - busy drops at that edge.
  - No further bps_clk or mid_tick.
  - No frame_done.
  - A new tx_start runs a full, normal frame.
- Config error and latching:
  - div_int=1 with tx_start held 3 cycles gives cfg_err high 3 cycles, busy stays 0.
  - Changing div_int mid-frame from 5 to 9 leaves the spacing at 5.
- Reset and collisions:
  - rst_n low mid-frame clears all outputs at the next edge.
  - tx_start+tx_abort together in RUN aborts with no restart.
  - tx_start held continuously gives back-to-back frames, each separated by exactly one idle cycle.
